tri_bus_arbiter: RTL and testbench
==================================

TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter N_REQ, default 4: number of requesters sharing the tri-state bus.
REQ-003 Parameter MAX_HOLD, default 8: maximum consecutive drive cycles per grant, legal range 2..255.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester bus request, level-sensitive.
REQ-007 bus_en  output  N_REQ  one-hot-or-zero; each bit is the control input of one requester's bufif1 driver.
REQ-008 grant  output  N_REQ  one-hot-or-zero; current owner, which stays high through the turnaround cycle.
REQ-009 owner  output  clog2(N_REQ)  index of the current or most recent owner.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 All outputs SHALL be registered, with no combinational path from req to any output.
REQ-012 The FSM SHALL have three states: IDLE, DRIVE and TURN.
REQ-013 IDLE: if req is nonzero, the next state SHALL be DRIVE, with the winner chosen round-robin starting at index (last_owner+1) mod N_REQ.
REQ-014 Latency: req sampled high at edge k SHALL give the corresponding bus_en and grant bit high after edge k.
REQ-015 DRIVE: bus_en SHALL equal grant, and the hold counter SHALL increment every cycle starting from 0.
REQ-016 DRIVE -> TURN SHALL occur when the owner's req bit is sampled low, or when the hold counter equals MAX_HOLD-1.
- In the second case the owner has driven for exactly MAX_HOLD cycles.
REQ-017 TURN SHALL last exactly one cycle with bus_en all zero, so that drivers never overlap.
REQ-018 TURN -> DRIVE SHALL occur if req is nonzero, with the round-robin winner taken after the just-released owner.
- The just-released owner has the lowest priority but remains eligible if it is the only requester.
REQ-019 TURN -> IDLE SHALL occur if req is zero.
REQ-020 IDLE: bus_en and grant SHALL be zero, and owner SHALL hold its last value.
REQ-021 A req pulse that rises and falls while another requester owns the bus SHALL NOT be remembered; requests are level-only.
REQ-022 Invariant: at most one bus_en bit is high in any cycle, and no bus_en bit rises in the cycle directly after a different bus_en bit was high.
REQ-023 The hold counter SHALL be clog2(MAX_HOLD) bits wide, SHALL clear on every entry into DRIVE, and SHALL never wrap while in DRIVE.

Reset
REQ-024 reset high at a rising edge SHALL force IDLE, with bus_en=0, grant=0, owner=0, busy=0, the hold counter at 0 and last_owner=N_REQ-1, so that index 0 has first priority.
REQ-025 Reset asserted during DRIVE SHALL drop bus_en to zero after that same edge, with no TURN cycle.
REQ-026 Reset SHALL take priority over every other transition.

Structure
REQ-027 The state encodings (IDLE=2'd0, DRIVE=2'd1, TURN=2'd2) and the default parameter values SHALL reside in the shared package tri_bus_pkg.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_pick, with inputs req and last_owner and outputs a one-hot pick and its index.
REQ-029 The top level SHALL contain only the FSM, the hold counter and the output registers.

Verification
REQ-030 Reset, then req=4'b0001 held for 3 cycles -> bus_en=0001 for 3 cycles, then 1 TURN cycle with bus_en=0000, then IDLE with busy=0.
REQ-031 req=4'b1111 held for 40 cycles -> owners 0,1,2,3,0 in sequence, each with 8 DRIVE cycles followed by 1 TURN cycle.
REQ-032 Owner 2 releases while req=4'b0101 -> next owner is 0, because the scan after 2 is 3 then 0.
REQ-033 reset pulsed during DRIVE with owner=3 -> next cycle bus_en=0, owner=0, busy=0; a subsequent req=4'b1000 is granted on the following edge.
REQ-034 req=4'b0010 only, held for 20 cycles -> the pattern 8 DRIVE, 1 TURN repeats for owner 1.
REQ-035 Random req for 10k cycles -> an assertion checks REQ-022 every cycle and checks that no DRIVE run exceeds MAX_HOLD cycles.

Source files
------------

// File: rtl/tri_bus_pkg.sv
// tri_bus_pkg: shared FSM encoding and default sizing for the tri-state bus arbiter
package tri_bus_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, TURN = 2'd2} state_e;
    localparam int N_REQ_DEF = 4;
    localparam int MAX_HOLD_DEF = 8;
endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner, scanning upward from last_owner+1
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_owner,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;
    // Scan farthest-first so the nearest requester after last_owner overwrites last.
    always_comb begin
        pick = '0;
        idx  = '0;
        j    = '0;
        for (int i = N; i >= 1; i--) begin
            j = IW'((int'(last_owner) + i) % N);
            if (req[j]) begin
                pick    = '0;
                pick[j] = 1'b1;
                idx     = j;
            end
        end
    end
endmodule

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner of a shared tri-state bus with a hold limit and one-cycle turnaround
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] bus_en,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    owner,
    output logic             busy
);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [IW-1:0]    owner_q, owner_d, last_q, last_d, pick_idx;
    logic [N_REQ-1:0] grant_q, grant_d, bus_en_q, bus_en_d, pick;
    logic             take;

    rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
        .req        (req),
        .last_owner (last_q),
        .pick       (pick),
        .idx        (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            owner_q  <= '0;
            last_q   <= IW'(N_REQ - 1);
            grant_q  <= '0;
            bus_en_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            bus_en_q <= bus_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, TURN: state_d = |req ? DRIVE : IDLE;
            DRIVE:      state_d = (!req[owner_q] || hold_q == HOLD_LAST) ? TURN : DRIVE;
            default:    state_d = IDLE;
        endcase
    end

    // A new winner is only taken from IDLE or TURN, so drivers never hand over directly.
    always_comb begin
        take     = (state_q != DRIVE) && |req;
        owner_d  = take ? pick_idx : owner_q;
        last_d   = take ? pick_idx : last_q;
        hold_d   = (state_q == DRIVE && state_d == DRIVE) ? hold_q + 1'b1 : '0;
        grant_d  = take ? pick : ((state_d == IDLE) ? '0 : grant_q);
        bus_en_d = (state_d == DRIVE) ? grant_d : '0;
    end

    assign bus_en = bus_en_q;
    assign grant  = grant_q;
    assign owner  = owner_q;
    assign busy   = state_q != IDLE;
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb_tri_bus_arbiter: scoreboard bench comparing the arbiter against a cycle-level reference model
module tb_tri_bus_arbiter;
    localparam int N  = 4;
    localparam int MH = 8;

    typedef struct packed {
        logic [3:0] bus_en;
        logic [3:0] grant;
        logic [1:0] owner;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] bus_en, grant;
    logic [1:0] owner;
    logic       busy;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t exp_q[$];
    int   starts[$];
    logic [3:0] prev_bus = '0;
    int   m_state = 0, m_hold = 0, m_owner = 0, m_last = N - 1;
    logic [3:0] mon_prev = '0;
    int   run = 0;

    always #5 clk = ~clk;

    tri_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .bus_en (bus_en),
        .grant  (grant),
        .owner  (owner),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    endtask

    // Reference: state 0=idle 1=drive 2=turn, outputs derived from owner index.
    task automatic model(input logic [3:0] r, input logic rs);
        exp_t e;
        logic [1:0] ix;
        if (rs) begin
            m_state = 0; m_hold = 0; m_owner = 0; m_last = N - 1;
        end else if (m_state == 1) begin
            ix = 2'(m_owner);
            if (!r[ix] || m_hold == MH - 1) m_state = 2;
            else m_hold++;
        end else if (r != 4'b0) begin
            for (int k = 1; k <= N; k++) begin
                ix = 2'((m_last + k) % N);
                if (r[ix]) begin
                    m_owner = int'(ix);
                    break;
                end
            end
            m_last = m_owner; m_state = 1; m_hold = 0;
        end else begin
            m_state = 0;
        end
        e.busy   = m_state != 0;
        e.owner  = 2'(m_owner);
        e.grant  = (m_state != 0) ? 4'(1 << m_owner) : 4'b0;
        e.bus_en = (m_state == 1) ? e.grant : 4'b0;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] r, input logic rs);
        exp_t e;
        req = r;
        reset = rs;
        model(r, rs);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("bus_en", 32'(bus_en), 32'(e.bus_en));
        chk("grant",  32'(grant),  32'(e.grant));
        chk("owner",  32'(owner),  32'(e.owner));
        chk("busy",   32'(busy),   32'(e.busy));
        if (bus_en != 4'b0 && prev_bus == 4'b0) starts.push_back(int'(owner));
        prev_bus = bus_en;
    endtask

    always @(negedge clk) begin
        int nr;
        nr = (bus_en != 4'b0 && bus_en == mon_prev) ? run + 1 : ((bus_en != 4'b0) ? 1 : 0);
        chk("onehot0", 32'($onehot0(bus_en)), 32'd1);
        chk("no_overlap", 32'(mon_prev != 4'b0 && bus_en != 4'b0 && bus_en != mon_prev), 32'd0);
        chk("hold_max", 32'(nr > MH), 32'd0);
        run <= nr;
        mon_prev <= bus_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        step(4'b0, 1'b1);
        step(4'b0, 1'b1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);

        repeat (3) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        chk("turn_bus", 32'(bus_en), 32'd0);
        chk("turn_grant", 32'(grant), 32'b0001);
        step(4'b0000, 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);

        step(4'b0, 1'b1);
        starts.delete();
        repeat (40) step(4'b1111, 1'b0);
        chk("rr_starts", 32'(starts.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("rr_seq", 32'((i < starts.size()) ? starts[i] : -1), 32'(i % 4));

        step(4'b0, 1'b1);
        step(4'b0100, 1'b0);
        repeat (9) step(4'b0101, 1'b0);
        chk("rr_after2_owner", 32'(owner), 32'd0);
        chk("rr_after2_bus", 32'(bus_en), 32'b0001);

        step(4'b0, 1'b1);
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        chk("own3", 32'(owner), 32'd3);
        step(4'b1000, 1'b1);
        chk("rst_drive_bus", 32'(bus_en), 32'd0);
        chk("rst_drive_owner", 32'(owner), 32'd0);
        chk("rst_drive_busy", 32'(busy), 32'd0);
        step(4'b1000, 1'b0);
        chk("post_rst_bus", 32'(bus_en), 32'b1000);

        step(4'b0, 1'b1);
        starts.delete();
        repeat (20) step(4'b0010, 1'b0);
        chk("solo_starts", 32'(starts.size()), 32'd3);
        chk("solo_bus", 32'(bus_en), 32'b0010);

        step(4'b0, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        chk("pulse_forgot", 32'(busy), 32'd0);

        r = 4'b0;
        repeat (10000) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            step(r, $urandom_range(299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
